// File: rtl/rcv_socket_bank.sv
// Receive socket bank: routes one UDP payload stream to the lowest-index matching socket FIFO,
// counting packets refused because the target FIFO was almost full at start of packet.
module rcv_socket_bank #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_en,
    input  logic [16*NCH-1:0]    cfg_my_port,
    input  logic [32*NCH-1:0]    cfg_my_ip,
    input  logic [16*NCH-1:0]    cfg_from_port,
    input  logic [32*NCH-1:0]    cfg_from_ip,
    input  logic [15:0]          s_udp_dst_port,
    input  logic [15:0]          s_udp_src_port,
    input  logic [31:0]          s_udp_dst_ip,
    input  logic [31:0]          s_udp_src_ip,
    input  logic [7:0]           s_udp_dout,
    input  logic                 s_udp_sof,
    input  logic                 s_udp_eof,
    input  logic                 s_udp_valid,
    input  logic [NCH-1:0]       fifo_afull,
    output logic [NCH-1:0]       fifo_wr,
    output logic [7:0]           fifo_dout,
    output logic                 fifo_sof,
    output logic                 fifo_eof,
    output logic [NCH-1:0]       fifo_abort,
    output logic [16*NCH-1:0]    src_port,
    output logic [32*NCH-1:0]    src_ip,
    output logic [CNT_W*NCH-1:0] drop_cnt
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                         state_q;
    logic [IW-1:0]                  ch_q;
    logic [NCH-1:0]                 wr_q, abort_q;
    logic                           sof_q, eof_q;
    logic [7:0]                     dout_q;
    logic [NCH-1:0][15:0]           src_port_q;
    logic [NCH-1:0][31:0]           src_ip_q;
    logic [NCH-1:0][CNT_W-1:0]      cnt_q;

    logic [NCH-1:0] hit;
    logic           any_hit;
    logic [IW-1:0]  sel;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hit[i] = ch_en[i]
                && (cfg_my_port[16*i +: 16]   == 16'hffff       || cfg_my_port[16*i +: 16]   == s_udp_dst_port)
                && (cfg_my_ip[32*i +: 32]     == 32'hffffffff   || cfg_my_ip[32*i +: 32]     == s_udp_dst_ip)
                && (cfg_from_port[16*i +: 16] == 16'hffff       || cfg_from_port[16*i +: 16] == s_udp_src_port)
                && (cfg_from_ip[32*i +: 32]   == 32'hffffffff   || cfg_from_ip[32*i +: 32]   == s_udp_src_ip);
        end
    end

    // Descending scan so the lowest-index hit wins.
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                sel     = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            wr_q       <= '0;
            abort_q    <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            src_port_q <= '0;
            src_ip_q   <= '0;
            cnt_q      <= '0;
        end else begin
            wr_q    <= '0;
            abort_q <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            if (s_udp_valid && s_udp_sof) begin
                // A new sof while still passing truncates the open packet.
                if (state_q == PASS)
                    abort_q[ch_q] <= 1'b1;
                if (!any_hit) begin
                    state_q <= s_udp_eof ? IDLE : DROP;
                end else if (fifo_afull[sel]) begin
                    state_q <= s_udp_eof ? IDLE : DROP;
                    if (cnt_q[sel] != '1)
                        cnt_q[sel] <= cnt_q[sel] + 1'b1;
                end else begin
                    state_q         <= s_udp_eof ? IDLE : PASS;
                    ch_q            <= sel;
                    wr_q[sel]       <= 1'b1;
                    sof_q           <= 1'b1;
                    eof_q           <= s_udp_eof;
                    src_port_q[sel] <= s_udp_src_port;
                    src_ip_q[sel]   <= s_udp_src_ip;
                end
            end else if (s_udp_valid && state_q == PASS) begin
                wr_q[ch_q] <= 1'b1;
                eof_q      <= s_udp_eof;
                if (s_udp_eof)
                    state_q <= IDLE;
            end else if (s_udp_valid && state_q == DROP && s_udp_eof) begin
                state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_udp_valid)
            dout_q <= s_udp_dout;
    end

    assign fifo_wr    = wr_q;
    assign fifo_abort = abort_q;
    assign fifo_sof   = sof_q;
    assign fifo_eof   = eof_q;
    assign fifo_dout  = dout_q;
    assign src_port   = src_port_q;
    assign src_ip     = src_ip_q;
    assign drop_cnt   = cnt_q;
endmodule

// File: tb/tb_rcv_socket_bank.sv
// Randomized + directed bench for rcv_socket_bank against a packet-level reference model.
module tb_rcv_socket_bank;
    localparam int NCH   = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NCH-1:0]       ch_en;
    logic [16*NCH-1:0]    cfg_my_port, cfg_from_port;
    logic [32*NCH-1:0]    cfg_my_ip, cfg_from_ip;
    logic [15:0]          s_udp_dst_port, s_udp_src_port;
    logic [31:0]          s_udp_dst_ip, s_udp_src_ip;
    logic [7:0]           s_udp_dout;
    logic                 s_udp_sof, s_udp_eof, s_udp_valid;
    logic [NCH-1:0]       fifo_afull;
    logic [NCH-1:0]       fifo_wr, fifo_abort;
    logic [7:0]           fifo_dout;
    logic                 fifo_sof, fifo_eof;
    logic [16*NCH-1:0]    src_port;
    logic [32*NCH-1:0]    src_ip;
    logic [CNT_W*NCH-1:0] drop_cnt;

    rcv_socket_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en),
        .cfg_my_port(cfg_my_port), .cfg_my_ip(cfg_my_ip),
        .cfg_from_port(cfg_from_port), .cfg_from_ip(cfg_from_ip),
        .s_udp_dst_port(s_udp_dst_port), .s_udp_src_port(s_udp_src_port),
        .s_udp_dst_ip(s_udp_dst_ip), .s_udp_src_ip(s_udp_src_ip),
        .s_udp_dout(s_udp_dout), .s_udp_sof(s_udp_sof), .s_udp_eof(s_udp_eof),
        .s_udp_valid(s_udp_valid), .fifo_afull(fifo_afull),
        .fifo_wr(fifo_wr), .fifo_dout(fifo_dout), .fifo_sof(fifo_sof), .fifo_eof(fifo_eof),
        .fifo_abort(fifo_abort), .src_port(src_port), .src_ip(src_ip), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: which socket the open packet is routed to (-1 = none), plus per-socket state.
    int          cur = -1;
    logic [15:0] m_sport [NCH];
    logic [31:0] m_sip   [NCH];
    int          m_cnt   [NCH];
    int          wr_tally[NCH];

    function automatic bit fmatch(input logic [31:0] cfg, input logic [31:0] hdr, input logic [31:0] wild);
        return (cfg == wild) || (cfg == hdr);
    endfunction

    function automatic int pick();
        for (int i = 0; i < NCH; i++)
            if (ch_en[i]
                && fmatch({16'h0, cfg_my_port[16*i +: 16]},   {16'h0, s_udp_dst_port}, 32'h0000ffff)
                && fmatch(cfg_my_ip[32*i +: 32],              s_udp_dst_ip,            32'hffffffff)
                && fmatch({16'h0, cfg_from_port[16*i +: 16]}, {16'h0, s_udp_src_port}, 32'h0000ffff)
                && fmatch(cfg_from_ip[32*i +: 32],            s_udp_src_ip,            32'hffffffff))
                return i;
        return -1;
    endfunction

    task automatic beat(input bit r, input bit v, input bit s, input bit e, input logic [7:0] d);
        logic [NCH-1:0] e_wr, e_ab;
        bit e_sof, e_eof;
        int k;
        rst = r; s_udp_valid = v; s_udp_sof = s; s_udp_eof = e; s_udp_dout = d;
        e_wr = '0; e_ab = '0; e_sof = 0; e_eof = 0;
        if (r) begin
            cur = -1;
            for (int i = 0; i < NCH; i++) begin m_sport[i] = '0; m_sip[i] = '0; m_cnt[i] = 0; end
        end else if (v && s) begin
            if (cur >= 0) e_ab[cur] = 1'b1;
            k = pick();
            cur = -1;
            if (k >= 0 && fifo_afull[k]) begin
                if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
            end else if (k >= 0) begin
                e_wr[k] = 1'b1; e_sof = 1; e_eof = e;
                m_sport[k] = s_udp_src_port; m_sip[k] = s_udp_src_ip;
                if (!e) cur = k;
            end
        end else if (v && cur >= 0) begin
            e_wr[cur] = 1'b1; e_eof = e;
            if (e) cur = -1;
        end
        @(posedge clk); #1;
        chk("wr", fifo_wr, e_wr);
        chk("abort", fifo_abort, e_ab);
        chk("sof", fifo_sof, e_sof);
        chk("eof", fifo_eof, e_eof);
        if (e_wr != 0) chk("dout", fifo_dout, d);
        for (int i = 0; i < NCH; i++) begin
            if (e_wr[i]) wr_tally[i]++;
            chk("src_port", src_port[16*i +: 16], m_sport[i]);
            chk("src_ip", src_ip[32*i +: 32], m_sip[i]);
            chk("drop_cnt", drop_cnt[CNT_W*i +: CNT_W], m_cnt[i]);
        end
    endtask

    task automatic hdr(input logic [15:0] dp, input logic [31:0] dip, input logic [15:0] sp, input logic [31:0] sip);
        s_udp_dst_port = dp; s_udp_dst_ip = dip; s_udp_src_port = sp; s_udp_src_ip = sip;
    endtask

    task automatic set_sock(input int i, input bit en, input logic [15:0] mp, input logic [31:0] mi,
                            input logic [15:0] fp, input logic [31:0] fi);
        ch_en[i] = en;
        cfg_my_port[16*i +: 16] = mp; cfg_my_ip[32*i +: 32] = mi;
        cfg_from_port[16*i +: 16] = fp; cfg_from_ip[32*i +: 32] = fi;
    endtask

    // gaps: insert an idle beat after every data beat; noeof: leave the packet open.
    task automatic pkt(input int len, input bit gaps, input bit noeof);
        for (int b = 0; b < len; b++) begin
            beat(0, 1, b == 0, (b == len - 1) && !noeof, 8'($urandom));
            if (gaps) beat(0, 0, 0, 0, 8'($urandom));
        end
    endtask

    task automatic clr_tally();
        for (int i = 0; i < NCH; i++) wr_tally[i] = 0;
    endtask

    logic [15:0] ports [4] = '{16'd5000, 16'd80, 16'd53, 16'hffff};
    logic [31:0] ips   [3] = '{32'hC0A8010A, 32'h0A000001, 32'hffffffff};

    initial begin
        ch_en = '0; cfg_my_port = '1; cfg_my_ip = '1; cfg_from_port = '1; cfg_from_ip = '1;
        fifo_afull = '0; hdr(0, 0, 0, 0);
        for (int i = 0; i < NCH; i++) begin m_sport[i] = '0; m_sip[i] = '0; m_cnt[i] = 0; end
        clr_tally();
        beat(1, 0, 0, 0, 0);
        beat(1, 1, 1, 0, 0);
        beat(0, 0, 0, 0, 0);

        // Socket 1 on port 5000 / 192.168.1.10, remote wildcards
        set_sock(1, 1, 16'd5000, 32'hC0A8010A, 16'hffff, 32'hffffffff);
        hdr(16'd5000, 32'hC0A8010A, 16'd1234, 32'h0A0A0A0A);
        clr_tally();
        pkt(4, 0, 0);
        chk("s1_writes", wr_tally[1], 4);
        chk("s1_src_port", src_port[31:16], 16'd1234);

        // Sockets 0 and 2 both wildcard: socket 0 wins
        set_sock(1, 0, '1, '1, '1, '1);
        set_sock(0, 1, '1, '1, '1, '1);
        set_sock(2, 1, '1, '1, '1, '1);
        clr_tally();
        pkt(3, 0, 0);
        chk("s0_writes", wr_tally[0], 3);
        chk("s2_writes", wr_tally[2], 0);

        // afull at sof drops and counts; afull rising mid-packet does not truncate
        fifo_afull[0] = 1'b1;
        clr_tally();
        for (int p = 0; p < 3; p++) pkt(3, 0, 0);
        chk("drop3_cnt", drop_cnt[CNT_W-1:0], 3);
        chk("drop3_writes", wr_tally[0], 0);
        fifo_afull[0] = 1'b0;
        beat(0, 1, 1, 0, 8'h11);
        fifo_afull[0] = 1'b1;
        beat(0, 1, 0, 0, 8'h22);
        beat(0, 1, 0, 1, 8'h33);
        chk("afull_mid_writes", wr_tally[0], 3);
        // saturation of the narrow counter
        for (int p = 0; p < 6; p++) pkt(2, 0, 0);
        chk("cnt_sat", drop_cnt[CNT_W-1:0], 7);
        fifo_afull[0] = 1'b0;

        // valid toggling mid-packet
        clr_tally();
        pkt(6, 1, 0);
        chk("gap_writes", wr_tally[0], 6);

        // Truncated packet then a normal one; then single-beat packet
        pkt(2, 0, 1);
        pkt(3, 0, 0);
        pkt(1, 0, 0);

        // Reset mid-PASS: no abort, remainder discarded
        beat(0, 1, 1, 0, 8'hA0);
        beat(0, 1, 0, 0, 8'hA1);
        beat(1, 1, 0, 0, 8'hA2);
        beat(0, 1, 0, 0, 8'hA3);
        beat(0, 1, 0, 1, 8'hA4);
        chk("rst_cnt0", drop_cnt, 0);

        // Randomized traffic
        for (int p = 0; p < 400; p++) begin
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < NCH; i++)
                    set_sock(i, $urandom_range(0, 3) != 0, ports[$urandom_range(0, 3)], ips[$urandom_range(0, 2)],
                             ($urandom_range(0, 2) == 0) ? ports[$urandom_range(0, 3)] : 16'hffff,
                             ($urandom_range(0, 2) == 0) ? ips[$urandom_range(0, 2)] : 32'hffffffff);
            hdr(ports[$urandom_range(0, 2)], ips[$urandom_range(0, 1)], ports[$urandom_range(0, 2)], ips[$urandom_range(0, 1)]);
            fifo_afull = NCH'($urandom) & NCH'($urandom);
            begin
                int len = $urandom_range(1, 6);
                bit open = ($urandom_range(0, 9) == 0);
                for (int b = 0; b < len; b++) begin
                    while ($urandom_range(0, 3) == 0) beat(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
                    beat($urandom_range(0, 199) == 0, 1, b == 0, (b == len - 1) && !open, 8'($urandom));
                    fifo_afull = NCH'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
